game_sequencer: RTL and testbench
=================================

GAME_SEQUENCER -- requirements
Module: game_sequencer

Interface
REQ-001 The block SHALL have parameter LIVES, default 3, meaning hits needed to win (range 1..15).
REQ-002 The block SHALL have parameter RST_CYCLES, default 4, meaning the bot reset/respawn hold length in clk cycles (≥1).
REQ-003 The block SHALL have parameter COOLDOWN, default 8, meaning the minimum clk cycles between fire grants per bot (≥1).
REQ-004 The block SHALL have parameter WIN_HOLD, default 16, meaning the cycles a win screen ignores start (≥1).
REQ-005 The block SHALL have port clk, input, 1 bit: clock; reset rstn, asynchronous, active-low; clock clk.
REQ-006 The block SHALL have port rstn, input, 1 bit: asynchronous active-low reset.
REQ-007 The block SHALL have port start_i, input, 1 bit: one-cycle start/continue pulse.
REQ-008 The block SHALL have port map_sel_i, input, 1 bit: 1 = map1, 0 = map2.
REQ-009 The block SHALL have port tank_hit_i, input, 1 bit: one-cycle pulse, tank bullet struck train.
REQ-010 The block SHALL have port train_hit_i, input, 1 bit: one-cycle pulse, train bullet struck tank.
REQ-011 The block SHALL have port fire_req_i, input, 2 bits: [0] tank, [1] train fire request (level).
REQ-012 The block SHALL have port frame_o, output, 5 bits: one-hot screen select ([0] start, [1] map1, [2] map2, [3] tank win, [4] train win).
REQ-013 The block SHALL have port bullet_o, output, 2 bits: one-cycle fire grant per bot.
REQ-014 The block SHALL have port bot_rst_o, output, 1 bit: active-high reset to both rojobots.
REQ-015 The block SHALL have ports tank_score_o and train_score_o, output, 4 bits each: hits scored.

Function
REQ-016 All outputs SHALL be registered; each output SHALL take its new value on the clk edge at which the causing input is sampled.
REQ-017 The FSM SHALL have states IDLE, ARM, PLAY, TANK_WIN and TRAIN_WIN.
REQ-018 IDLE SHALL drive frame_o=00001 and bot_rst_o=1; on start_i it SHALL latch map_sel_i, clear both scores and go to ARM.
REQ-019 ARM SHALL drive bot_rst_o=1 and the latched map frame, hold for exactly RST_CYCLES cycles, then go to PLAY.
REQ-020 PLAY SHALL drive bot_rst_o=0 and frame_o=00010 (map1) or 00100 (map2) per the latched map.
REQ-021 In PLAY, tank_hit_i SHALL increment tank_score_o and train_hit_i SHALL increment train_score_o; if the result is below LIVES the FSM SHALL go to ARM (respawn).
REQ-022 If only one score reaches LIVES, the FSM SHALL go to TANK_WIN (frame 01000) or TRAIN_WIN (frame 10000) accordingly.
REQ-023 On simultaneous hits where both scores reach LIVES, the FSM SHALL treat the result as a tie: clear both scores and go to ARM.
REQ-024 Win states SHALL hold bot_rst_o=1 and ignore start_i for WIN_HOLD cycles; the first start_i after that SHALL go to IDLE.
REQ-025 Hits and fire requests outside PLAY, start_i in ARM/PLAY, and map_sel_i changes after latching SHALL be ignored.
REQ-026 For each bot, in PLAY, fire_req_i high with that bot's cooldown at zero SHALL pulse bullet_o for exactly one cycle and load the cooldown with COOLDOWN; the cooldown SHALL decrement to 0 and saturate there.
REQ-027 Entering ARM SHALL clear both cooldowns; both bots MAY be granted in the same cycle.
REQ-028 Scores SHALL never exceed LIVES and SHALL hold their value through the win states.

Reset
REQ-029 While rstn=0: state IDLE, frame_o=00001, bullet_o=00, bot_rst_o=1, scores 0, cooldowns 0, latched map 1, all counters 0.
REQ-030 Reset asserted mid-game SHALL abort immediately with no pending grant; after release the block SHALL wait in IDLE.

Structure
REQ-031 The state enumeration and the frame index constants SHALL live in shared package game_seq_pkg.
REQ-032 The per-bot cooldown/grant logic SHALL be sub-module fire_cooldown, instantiated twice.

Verification
REQ-033 Reset, then start_i with map_sel_i=1 -> bot_rst_o high for 4 cycles, then frame_o=00010 and bot_rst_o=0.
REQ-034 In PLAY, fire_req_i[0] held high for 20 cycles -> bullet_o[0] pulses at cycles 0, 8 and 16 only.
REQ-035 Three tank_hit_i pulses separated by ≥5 cycles -> respawn (ARM) after hits 1 and 2, then TANK_WIN with frame_o=01000 and tank_score_o=3.
REQ-036 Scores at 2/2, then tank_hit_i and train_hit_i in the same cycle -> ARM, both scores 0.
REQ-037 In TRAIN_WIN, start_i at hold cycle 10 -> ignored; start_i at cycle 17 -> IDLE, frame_o=00001.
REQ-038 rstn pulsed low in PLAY while fire_req_i=11 -> bullet_o=00 and IDLE immediately.

Source files
------------

// File: rtl/game_seq_pkg.sv
// rtl/game_seq_pkg.sv - shared state encoding and screen-select helpers for the game sequencer
package game_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    PLAY,
    TANK_WIN,
    TRAIN_WIN
  } state_t;

  localparam int FRAME_W         = 5;
  localparam int FRAME_START     = 0;
  localparam int FRAME_MAP1      = 1;
  localparam int FRAME_MAP2      = 2;
  localparam int FRAME_TANK_WIN  = 3;
  localparam int FRAME_TRAIN_WIN = 4;

  // One-hot screen select shown while in state s with the latched map.
  function automatic logic [FRAME_W-1:0] frame_for(input state_t s, input logic map1);
    logic [FRAME_W-1:0] f;
    f = '0;
    case (s)
      IDLE:      f[FRAME_START] = 1'b1;
      ARM, PLAY: f[map1 ? FRAME_MAP1 : FRAME_MAP2] = 1'b1;
      TANK_WIN:  f[FRAME_TANK_WIN] = 1'b1;
      default:   f[FRAME_TRAIN_WIN] = 1'b1;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/fire_cooldown.sv
// rtl/fire_cooldown.sv - per-bot fire grant with a minimum spacing of COOLDOWN cycles
module fire_cooldown #(
  parameter int COOLDOWN = 8
) (
  input  logic clk,
  input  logic rstn,
  input  logic enable,
  input  logic clear,
  input  logic fire_req,
  output logic grant
);

  localparam int W = $clog2(COOLDOWN + 1);

  logic [W-1:0] cd;
  logic [W-1:0] cd_dec;

  // Grant eligibility looks at the post-decrement value so grants land exactly COOLDOWN apart.
  assign cd_dec = (cd == '0) ? '0 : cd - W'(1);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cd    <= '0;
      grant <= 1'b0;
    end else if (clear) begin
      cd    <= '0;
      grant <= 1'b0;
    end else if (enable && fire_req && cd_dec == '0) begin
      cd    <= W'(COOLDOWN);
      grant <= 1'b1;
    end else begin
      cd    <= cd_dec;
      grant <= 1'b0;
    end
  end

endmodule

// File: rtl/game_sequencer.sv
// rtl/game_sequencer.sv - two-bot arena game sequencer: screens, respawn, scoring, fire grants
module game_sequencer
  import game_seq_pkg::*;
#(
  parameter int LIVES      = 3,
  parameter int RST_CYCLES = 4,
  parameter int COOLDOWN   = 8,
  parameter int WIN_HOLD   = 16
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               start_i,
  input  logic               map_sel_i,
  input  logic               tank_hit_i,
  input  logic               train_hit_i,
  input  logic [1:0]         fire_req_i,
  output logic [FRAME_W-1:0] frame_o,
  output logic [1:0]         bullet_o,
  output logic               bot_rst_o,
  output logic [3:0]         tank_score_o,
  output logic [3:0]         train_score_o
);

  localparam int CNT_MAX = (RST_CYCLES > WIN_HOLD) ? RST_CYCLES : WIN_HOLD;
  localparam int CW      = $clog2(CNT_MAX + 1);

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          map_q, map_n;
  logic [3:0]    tank_n, train_n, tank_inc, train_inc;
  logic          tank_won, train_won, play_stay, arm_entry;

  assign tank_inc  = tank_score_o + {3'b000, tank_hit_i};
  assign train_inc = train_score_o + {3'b000, train_hit_i};
  assign tank_won  = (tank_inc == 4'(LIVES));
  assign train_won = (train_inc == 4'(LIVES));

  always_comb begin
    state_n = state;
    map_n   = map_q;
    tank_n  = tank_score_o;
    train_n = train_score_o;
    case (state)
      IDLE: if (start_i) begin
        map_n   = map_sel_i;
        tank_n  = '0;
        train_n = '0;
        state_n = ARM;
      end
      ARM: if (cnt == CW'(RST_CYCLES - 1)) state_n = PLAY;
      PLAY: if (tank_hit_i || train_hit_i) begin
        if (tank_won && train_won) begin
          tank_n  = '0;
          train_n = '0;
          state_n = ARM;
        end else begin
          tank_n  = tank_inc;
          train_n = train_inc;
          if (tank_won)       state_n = TANK_WIN;
          else if (train_won) state_n = TRAIN_WIN;
          else                state_n = ARM;
        end
      end
      TANK_WIN, TRAIN_WIN: if (start_i && cnt >= CW'(WIN_HOLD)) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Dwell counter restarts on every state change and saturates.
  assign cnt_n     = (state_n != state) ? '0 : (cnt == CW'(CNT_MAX)) ? cnt : cnt + CW'(1);
  assign play_stay = (state == PLAY) && (state_n == PLAY);
  assign arm_entry = (state_n == ARM) && (state != ARM);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state         <= IDLE;
      cnt           <= '0;
      map_q         <= 1'b1;
      tank_score_o  <= '0;
      train_score_o <= '0;
      frame_o       <= frame_for(IDLE, 1'b1);
      bot_rst_o     <= 1'b1;
    end else begin
      state         <= state_n;
      cnt           <= cnt_n;
      map_q         <= map_n;
      tank_score_o  <= tank_n;
      train_score_o <= train_n;
      frame_o       <= frame_for(state_n, map_n);
      bot_rst_o     <= (state_n != PLAY);
    end
  end

  fire_cooldown #(.COOLDOWN(COOLDOWN)) u_tank_fire (
    .clk      (clk),
    .rstn     (rstn),
    .enable   (play_stay),
    .clear    (arm_entry),
    .fire_req (fire_req_i[0]),
    .grant    (bullet_o[0])
  );

  fire_cooldown #(.COOLDOWN(COOLDOWN)) u_train_fire (
    .clk      (clk),
    .rstn     (rstn),
    .enable   (play_stay),
    .clear    (arm_entry),
    .fire_req (fire_req_i[1]),
    .grant    (bullet_o[1])
  );

endmodule

// File: tb/tb_game_sequencer.sv
// tb/tb_game_sequencer.sv - self-checking bench for game_sequencer (vector table, corner sequences, random vs model)
module tb_game_sequencer;

  localparam int LIVES = 3, RST_CYCLES = 4, COOLDOWN = 8, WIN_HOLD = 16;
  localparam int M_IDLE = 0, M_ARM = 1, M_PLAY = 2, M_TWIN = 3, M_RWIN = 4;

  logic       clk, rstn, start_i, map_sel_i, tank_hit_i, train_hit_i;
  logic [1:0] fire_req_i, bullet_o;
  logic [4:0] frame_o;
  logic       bot_rst_o;
  logic [3:0] tank_score_o, train_score_o;

  game_sequencer #(.LIVES(LIVES), .RST_CYCLES(RST_CYCLES), .COOLDOWN(COOLDOWN), .WIN_HOLD(WIN_HOLD)) dut (
    .clk(clk), .rstn(rstn), .start_i(start_i), .map_sel_i(map_sel_i),
    .tank_hit_i(tank_hit_i), .train_hit_i(train_hit_i), .fire_req_i(fire_req_i),
    .frame_o(frame_o), .bullet_o(bullet_o), .bot_rst_o(bot_rst_o),
    .tank_score_o(tank_score_o), .train_score_o(train_score_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0, checks = 0, k = 0;

  // Reference model: game phase plus timestamps (edge numbers) of phase entry and last grants.
  int m_mode, m_map, m_tank, m_train, m_arm_k, m_win_k, m_bullet;
  int m_last [2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, k);
    end
  endtask

  task automatic m_reset();
    m_mode = M_IDLE; m_map = 1; m_tank = 0; m_train = 0; m_bullet = 0;
    m_last[0] = -1000; m_last[1] = -1000;
  endtask

  task automatic m_enter_arm();
    m_mode = M_ARM; m_arm_k = k;
    m_last[0] = -1000; m_last[1] = -1000;
  endtask

  task automatic model_step(input int s, input int sel, input int th, input int trh, input int fr);
    int t, r;
    m_bullet = 0;
    case (m_mode)
      M_IDLE: if (s != 0) begin
        m_map = sel; m_tank = 0; m_train = 0; m_enter_arm();
      end
      M_ARM: if (k - m_arm_k == RST_CYCLES) m_mode = M_PLAY;
      M_PLAY: begin
        t = m_tank + th; r = m_train + trh;
        if (th != 0 || trh != 0) begin
          if (t == LIVES && r == LIVES) begin
            m_tank = 0; m_train = 0; m_enter_arm();
          end else begin
            m_tank = t; m_train = r;
            if (t == LIVES)      begin m_mode = M_TWIN; m_win_k = k; end
            else if (r == LIVES) begin m_mode = M_RWIN; m_win_k = k; end
            else m_enter_arm();
          end
        end else begin
          for (int b = 0; b < 2; b++)
            if (fr[b] && k - m_last[b] >= COOLDOWN) begin
              m_bullet |= (1 << b); m_last[b] = k;
            end
        end
      end
      default: if (s != 0 && k - m_win_k >= WIN_HOLD + 1) m_mode = M_IDLE;
    endcase
  endtask

  function automatic int exp_frame();
    case (m_mode)
      M_IDLE:        return 1;
      M_ARM, M_PLAY: return (m_map != 0) ? 2 : 4;
      M_TWIN:        return 8;
      default:       return 16;
    endcase
  endfunction

  task automatic check_model();
    chk("frame", 32'(frame_o), exp_frame());
    chk("bullet", 32'(bullet_o), m_bullet);
    chk("bot_rst", 32'(bot_rst_o), (m_mode == M_PLAY) ? 0 : 1);
    chk("tank_score", 32'(tank_score_o), m_tank);
    chk("train_score", 32'(train_score_o), m_train);
  endtask

  task automatic drive(input int s, input int sel, input int th, input int trh, input int fr);
    start_i = s[0]; map_sel_i = sel[0]; tank_hit_i = th[0]; train_hit_i = trh[0]; fire_req_i = fr[1:0];
  endtask

  task automatic step(input int s, input int sel, input int th, input int trh, input int fr);
    drive(s, sel, th, trh, fr);
    @(posedge clk); k++;
    model_step(s, sel, th, trh, fr);
    #1 check_model();
  endtask

  task automatic wait_play();
    for (int i = 0; i < 20 && m_mode != M_PLAY; i++) step(0, 0, 0, 0, 0);
    chk("reach_play", 32'(bot_rst_o), 0);
  endtask

  typedef struct {
    int s, sel, th, trh, fr;
    logic [4:0] frame; logic [1:0] bul; logic rst; logic [3:0] ts, rs;
  } vec_t;
  vec_t vt [10];

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    logic [31:0] mask;
    vt[0] = '{1, 1, 0, 0, 0, 5'b00010, 2'b00, 1'b1, 4'd0, 4'd0};
    vt[1] = '{0, 0, 0, 0, 0, 5'b00010, 2'b00, 1'b1, 4'd0, 4'd0};
    vt[2] = '{0, 0, 1, 0, 0, 5'b00010, 2'b00, 1'b1, 4'd0, 4'd0};
    vt[3] = '{0, 0, 0, 0, 3, 5'b00010, 2'b00, 1'b1, 4'd0, 4'd0};
    vt[4] = '{0, 0, 0, 0, 0, 5'b00010, 2'b00, 1'b0, 4'd0, 4'd0};
    vt[5] = '{0, 0, 0, 0, 1, 5'b00010, 2'b01, 1'b0, 4'd0, 4'd0};
    vt[6] = '{0, 0, 0, 0, 1, 5'b00010, 2'b00, 1'b0, 4'd0, 4'd0};
    vt[7] = '{1, 0, 0, 0, 2, 5'b00010, 2'b10, 1'b0, 4'd0, 4'd0};
    vt[8] = '{0, 0, 0, 1, 3, 5'b00010, 2'b00, 1'b1, 4'd0, 4'd1};
    vt[9] = '{0, 0, 0, 0, 3, 5'b00010, 2'b00, 1'b1, 4'd0, 4'd1};

    rstn = 1'b0; drive(0, 0, 0, 0, 0); m_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_frame", 32'(frame_o), 32'h1);
    chk("rst_bullet", 32'(bullet_o), 32'h0);
    chk("rst_bot_rst", 32'(bot_rst_o), 32'h1);
    chk("rst_scores", {24'h0, tank_score_o, train_score_o}, 32'h0);
    rstn = 1'b1;

    foreach (vt[i]) begin
      drive(vt[i].s, vt[i].sel, vt[i].th, vt[i].trh, vt[i].fr);
      @(posedge clk); k++;
      model_step(vt[i].s, vt[i].sel, vt[i].th, vt[i].trh, vt[i].fr);
      #1;
      chk($sformatf("vec%0d_frame", i), 32'(frame_o), 32'(vt[i].frame));
      chk($sformatf("vec%0d_bullet", i), 32'(bullet_o), 32'(vt[i].bul));
      chk($sformatf("vec%0d_bot_rst", i), 32'(bot_rst_o), 32'(vt[i].rst));
      chk($sformatf("vec%0d_tank", i), 32'(tank_score_o), 32'(vt[i].ts));
      chk($sformatf("vec%0d_train", i), 32'(train_score_o), 32'(vt[i].rs));
    end

    wait_play();
    mask = '0;
    for (int i = 0; i < 20; i++) begin
      step(0, 0, 0, 0, 1);
      mask[i] = bullet_o[0];
    end
    chk("fire_cadence", mask, 32'h10101);

    step(0, 0, 0, 0, 3);
    rstn = 1'b0;
    #1;
    chk("abort_bullet", 32'(bullet_o), 32'h0);
    chk("abort_frame", 32'(frame_o), 32'h1);
    chk("abort_bot_rst", 32'(bot_rst_o), 32'h1);
    drive(0, 0, 0, 0, 0); m_reset();
    @(posedge clk); @(posedge clk);
    #1 rstn = 1'b1;
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);

    step(1, 0, 0, 0, 0);
    chk("map2_frame", 32'(frame_o), 32'h4);
    wait_play();
    step(0, 0, 1, 0, 0);
    chk("hit1_respawn", {27'h0, bot_rst_o, tank_score_o}, 32'h11);
    wait_play(); step(0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    chk("hit2_respawn", {27'h0, bot_rst_o, tank_score_o}, 32'h12);
    wait_play(); step(0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    chk("tank_win_frame", 32'(frame_o), 32'h8);
    chk("tank_win_score", 32'(tank_score_o), 32'h3);
    for (int c = 0; c < WIN_HOLD; c++) step(0, 0, 0, 0, 0);
    chk("tank_win_score_held", 32'(tank_score_o), 32'h3);
    step(1, 0, 0, 0, 0);
    chk("tank_win_exit", 32'(frame_o), 32'h1);

    step(1, 1, 0, 0, 0);
    wait_play();
    for (int i = 0; i < 4; i++) begin
      step(0, 0, i % 2, (i + 1) % 2, 0);
      wait_play();
    end
    chk("pre_tie_scores", {24'h0, tank_score_o, train_score_o}, 32'h22);
    step(0, 0, 1, 1, 0);
    chk("tie_bot_rst", 32'(bot_rst_o), 32'h1);
    chk("tie_scores", {24'h0, tank_score_o, train_score_o}, 32'h00);
    chk("tie_frame", 32'(frame_o), 32'h2);
    wait_play();

    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 1, 0);
      if (i < 2) wait_play();
    end
    chk("train_win_frame", 32'(frame_o), 32'h10);
    for (int c = 0; c < 10; c++) step(0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    chk("win_hold_ignore", 32'(frame_o), 32'h10);
    for (int c = 11; c < 17; c++) step(0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    chk("train_win_exit", 32'(frame_o), 32'h1);

    for (int i = 0; i < 3000; i++)
      step(int'($urandom_range(0, 7) == 0), int'($urandom_range(0, 1)),
           int'($urandom_range(0, 11) == 0), int'($urandom_range(0, 11) == 0),
           int'($urandom_range(0, 3)));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
